// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command/response engine.
// Holds the opcode encodings, operand/result widths, the command and response
// payload structs, and the ALU evaluation function.
package alu_pkg;

  localparam int unsigned OPD_W = 4;
  localparam int unsigned RES_W = 5;
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  // Command held in the S1 stage.
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [OPD_W-1:0] a;
    logic [OPD_W-1:0] b;
  } cmd_t;

  // Result entry stored in the response FIFO (opcode tag + result).
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [RES_W-1:0] res;
  } rsp_t;

  // 5-bit result; bit 4 is carry for ADD and borrow for SUB.
  function automatic logic [RES_W-1:0] alu_eval(input logic [OP_W-1:0]  op,
                                                input logic [OPD_W-1:0] a,
                                                input logic [OPD_W-1:0] b);
    logic [RES_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOT:  r = {1'b0, ~a};
      OP_SHL:  r = {a, 1'b0};
      OP_SHR:  r = {2'b00, a[3:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous result FIFO with registered head outputs.
// Ports: clk, rst (async active-high), push/din write side, pop read side,
// dout/valid registered head view (dout is zero when empty), count occupancy.
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  rsp_t                         din,
  input  logic                         pop,
  output rsp_t                         dout,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(DEPTH+1);

  rsp_t              mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_n;
  logic [PTR_W-1:0]  rd_ptr_n;
  logic [FCNT_W-1:0] count_n;
  logic              do_push;
  logic              do_pop;
  rsp_t              head_n;

  // Push into a full FIFO is allowed only when a pop frees a slot on the same edge.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FCNT_W'(DEPTH)) || do_pop);

  // Next pointers/count, and next head value so dout/valid can be registered.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count;
    if (do_push) wr_ptr_n = wr_ptr + PTR_W'(1);
    if (do_pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
    if (do_push && !do_pop) count_n = count + FCNT_W'(1);
    if (do_pop && !do_push) count_n = count - FCNT_W'(1);
    head_n = mem[rd_ptr_n];
    if (do_push && (wr_ptr == rd_ptr_n)) head_n = din;
    if (count_n == '0) head_n = '0;
  end

  // Storage array; stale contents are masked by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and registered head view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      dout   <= head_n;
      valid  <= (count_n != '0);
    end
  end

endmodule

// File: rtl/alu_op_responder.sv
// Command/response engine for the 4-bit ALU operation set.
// Ports: clk, rst (async active-high); command channel cmd_valid/cmd_ready with
// cmd_op/cmd_a/cmd_b; response channel rsp_valid/rsp_ready with rsp_out/rsp_op;
// ops_done counts consumed results and wraps.
module alu_op_responder
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4:0]       rsp_out,
  output logic [2:0]       rsp_op,
  output logic [CNT_W-1:0] ops_done
);

  localparam int unsigned FCNT_W = $clog2(DEPTH+1);
  localparam int unsigned OCC_W  = FCNT_W + 1;

  cmd_t              s1_q;
  logic              s1_valid;
  rsp_t              s1_rsp;
  rsp_t              fifo_dout;
  logic [FCNT_W-1:0] fifo_count;
  logic              accept;
  logic              rsp_pop;
  logic [OCC_W-1:0]  occ_n;

  assign accept  = cmd_valid && cmd_ready;
  assign rsp_pop = rsp_valid && rsp_ready;

  // S1 drains into the FIFO every edge; it stays full only if refilled on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_q <= '{op: cmd_op, a: cmd_a, b: cmd_b};
    end
  end

  assign s1_rsp = '{op: s1_q.op, res: alu_eval(s1_q.op, s1_q.a, s1_q.b)};

  alu_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_valid),
    .din   (s1_rsp),
    .pop   (rsp_pop),
    .dout  (fifo_dout),
    .valid (rsp_valid),
    .count (fifo_count)
  );

  assign rsp_out = fifo_dout.res;
  assign rsp_op  = fifo_dout.op;

  // Credit: next-cycle occupancy of S1 plus FIFO, registered into cmd_ready.
  assign occ_n = OCC_W'(fifo_count) + OCC_W'(s1_valid) + OCC_W'(accept) - OCC_W'(rsp_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b0;
    end else begin
      cmd_ready <= (occ_n < OCC_W'(DEPTH));
    end
  end

  // Consumed-result counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done <= '0;
    end else if (rsp_pop) begin
      ops_done <= ops_done + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_responder.sv
// Self-checking bench for alu_op_responder: directed phases plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_alu_op_responder;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_out;
  logic [2:0] rsp_op;
  logic [7:0] ops_done;

  logic       cmd_ready2;
  logic       rsp_valid2;
  logic [4:0] rsp_out2;
  logic [2:0] rsp_op2;
  logic [1:0] ops_done2;

  always #5 clk = ~clk;

  alu_op_responder #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_op(rsp_op), .ops_done(ops_done)
  );

  alu_op_responder #(.DEPTH(DEPTH), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid2),
    .rsp_ready(rsp_ready), .rsp_out(rsp_out2), .rsp_op(rsp_op2), .ops_done(ops_done2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  res;
    logic [2:0]  op;
    int unsigned vis;
  } ent_t;

  ent_t        q[$];
  int unsigned cyc = 0;
  int unsigned outstanding = 0;
  int unsigned pops = 0;
  int unsigned acc_obs = 0;
  bit          rdy_block = 1'b1;
  bit          use_dir = 1'b0;
  logic [4:0]  dir_exp = '0;

  // Reference ALU computed with plain integer arithmetic.
  function automatic logic [4:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    case (op)
      3'd0: r = ia + ib;
      3'd1: r = (ia - ib + 32) % 32;
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 15 - ia;
      3'd6: r = ia * 2;
      default: r = ia / 2;
    endcase
    return 5'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge, then advance the model across the posedge.
  task automatic cycle();
    logic       exp_rdy;
    logic       exp_vld;
    logic       acc;
    logic       pop;
    logic [2:0] cop;
    logic [4:0] cres;
    @(negedge clk);
    exp_rdy = !rst && !rdy_block && (outstanding < DEPTH);
    exp_vld = !rst && (q.size() > 0) && (cyc >= q[0].vis);
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    chk("rsp_out", 32'(rsp_out), exp_vld ? 32'(q[0].res) : 32'd0);
    chk("rsp_op", 32'(rsp_op), exp_vld ? 32'(q[0].op) : 32'd0);
    chk("ops_done", 32'(ops_done), pops % 256);
    chk("ops_done_w2", 32'(ops_done2), pops % 4);
    if (cmd_valid && cmd_ready) acc_obs++;
    acc  = exp_rdy && cmd_valid;
    pop  = exp_vld && rsp_ready;
    cop  = cmd_op;
    cres = use_dir ? dir_exp : ref_alu(cmd_op, cmd_a, cmd_b);
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      outstanding = 0;
      pops        = 0;
      rdy_block   = 1'b1;
    end else begin
      rdy_block = 1'b0;
      if (pop) begin
        void'(q.pop_front());
        outstanding--;
        pops++;
      end
      if (acc) begin
        q.push_back('{res: cres, op: cop, vis: cyc + 1});
        outstanding++;
      end
    end
    #1;
  endtask

  task automatic rand_cmd();
    cmd_op = 3'($urandom_range(0, 7));
    cmd_a  = 4'($urandom_range(0, 15));
    cmd_b  = 4'($urandom_range(0, 15));
  endtask

  logic [2:0]  d_op  [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [3:0]  d_a   [8] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0101, 4'b1111, 4'b1111, 4'b1111};
  logic [3:0]  d_b   [8] = '{4'b1111, 4'b1000, 4'b0011, 4'b1100, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
  logic [4:0]  d_exp [8] = '{5'b11110, 5'b00111, 5'b00011, 5'b01111, 5'b01111, 5'b00000, 5'b11110, 5'b00111};
  int unsigned acc_base;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;

    // Reset state.
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    cycle();

    // Per-op directed results against known values.
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      use_dir   = 1'b1;
      dir_exp   = d_exp[i];
      cmd_op    = d_op[i];
      cmd_a     = d_a[i];
      cmd_b     = d_b[i];
      cmd_valid = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      use_dir   = 1'b0;
      for (int k = 0; k < 3; k++) cycle();
    end

    // Back-to-back commands: latency and full throughput.
    for (int i = 0; i < 8; i++) begin
      rand_cmd();
      cmd_valid = 1'b1;
      cycle();
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) cycle();

    // Backpressure: exactly DEPTH accepted, head stable while stalled.
    rsp_ready = 1'b0;
    acc_base  = acc_obs;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_cmd();
      cycle();
    end
    chk("bp_accepts", acc_obs - acc_base, DEPTH);

    // Full: one pop frees exactly one credit for the pending command.
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    chk("full_swap_accepts", acc_obs - acc_base, DEPTH + 1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) cycle();

    // Reset mid-operation with 3 results queued.
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_cmd();
      cycle();
    end
    cmd_valid = 1'b0;
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_ops_done", 32'(ops_done), 32'd0);
    chk("async_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("async_rsp_out", 32'(rsp_out), 32'd0);
    q.delete();
    outstanding = 0;
    pops        = 0;
    rdy_block   = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Single command after reset, then four more: narrow counter wraps.
    rsp_ready = 1'b1;
    rand_cmd();
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_cmd();
      cycle();
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    chk("wrap_ops_done_w2", 32'(ops_done2), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_cmd();
      cmd_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
